aespim_dec_unit: RTL and testbench
==================================

AESPIM_DEC_UNIT -- requirements
Module: aespim_dec_unit

Interface
REQ-001 SHALL have port clk_i, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_i, input, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL have port in_valid_i, input, 1 bit: request valid.
REQ-004 SHALL have port in_ready_o, output, 1 bit: unit can accept a request.
REQ-005 SHALL have port mode_i, input, 2 bits: 2'b00 DECI (add key only), 2'b01 DECM (middle inverse round), 2'b10 DECF (final inverse round), 2'b11 reserved, executed as DECI.
REQ-006 SHALL have port data_i, input, 128 bits: state; byte k (FIPS-197 order, k=0..15) at data_i[127-8k -: 8], column c = bytes 4c..4c+3, row r = k mod 4.
REQ-007 SHALL have port key_i, input, 128 bits: round key, same byte order as data_i.
REQ-008 SHALL have port out_valid_o, output, 1 bit: result valid.
REQ-009 SHALL have port out_ready_i, input, 1 bit: consumer accepts the result.
REQ-010 SHALL have port data_o, output, 128 bits: result, same byte order as data_i.

Function
REQ-011 SHALL implement FSM states IDLE, COL, DONE; in_ready_o=1 only in IDLE; out_valid_o=1 only in DONE.
REQ-012 SHALL accept a request on a cycle with in_valid_i & in_ready_o, latching data_i, key_i and mode_i; inputs are ignored in every other cycle.
REQ-013 SHALL, on accepting DECI/reserved, load data_o register with data_i ^ key_i and go IDLE->DONE (out_valid_o one cycle after acceptance).
REQ-014 SHALL, on accepting DECM/DECF, go IDLE->COL with 2-bit column counter 0, processing one column per cycle for columns 0,1,2,3, then COL->DONE; out_valid_o asserts five cycles after acceptance.
REQ-015 SHALL per COL cycle compute output column c: InvShiftRows (row r byte taken from latched column (c-r) mod 4), InvSubBytes via four combinational inverse S-box lookups, XOR key column c, then InvMixColumns (matrix 0e 0b 0d 09, GF(2^8) modulo 0x11b) for DECM only; DECF skips InvMixColumns.
REQ-016 SHALL write each computed column into the result register at column c only; unwritten columns are don't-care until DONE.
REQ-017 SHALL read InvShiftRows sources only from the latched input register, never from partially written results.
REQ-018 SHALL hold data_o and out_valid_o stable in DONE while out_ready_i=0 for any number of cycles.
REQ-019 SHALL go DONE->IDLE on out_valid_o & out_ready_i; in_ready_o rises in the following cycle (no same-cycle accept), giving one request per 2 cycles (DECI) or 6 cycles (DECM/DECF) at best.
REQ-020 SHALL ignore in_valid_i while in COL or DONE; no queuing.
REQ-021 SHALL wrap the column counter to 0 on COL->DONE.

Reset
REQ-022 SHALL on rst_i=1 at a clock edge force state IDLE, column counter 0, out_valid_o=0, data_o=128'h0, in_ready_o=1 from the next cycle, regardless of current state (including mid-COL or DONE).
REQ-023 SHALL give rst_i priority over any simultaneous handshake; a request presented while rst_i=1 is not accepted.

Verification
REQ-024 DECI: data 69c4e0d86a7b0430d8cdb78070b4c55a, key 13111d7fe3944a17f307a78b4d2b30c5 -> data_o 7ad5fda789ef4e272bca100b3d9ff59f, out_valid_o one cycle after accept.
REQ-025 DECF: data 7ad5fda789ef4e272bca100b3d9ff59f, key 0 -> data_o bd6e7c3df2b5779e0b61216e8b10b689 five cycles after accept; repeat with data all 0x63, key all 0xff -> all 0xff.
REQ-026 DECM: data all 0x7c, key 0 -> all 0x01; and data whose InvSubBytes column equals 8e4da1bc (all columns), key 0 -> each output column db135345.
REQ-027 Backpressure: hold out_ready_i=0 for 10 cycles in DONE -> data_o/out_valid_o stable, in_ready_o=0, new in_valid_i pulses ignored; after out_ready_i=1, in_ready_o=1 next cycle.
REQ-028 Reset mid-operation: assert rst_i during COL column 2 -> next cycle IDLE, out_valid_o=0, data_o=0; following DECF request yields correct result with nominal five-cycle latency.

Source files
------------

// File: rtl/aespim_dec_unit.sv
// aespim_dec_unit: one AES decryption step per request.
//   DECI (mode 00, and reserved 11): data ^ key, result one cycle after accept.
//   DECM (mode 01): InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns.
//   DECF (mode 10): same as DECM without InvMixColumns.
//   DECM/DECF work one output column per cycle, so the result appears five
//   cycles after accept.
//
// Ports
//   clk_i        clock, rising edge
//   rst_i        synchronous active-high reset
//   in_valid_i   request valid       in_ready_o   high only when idle
//   mode_i       operation select
//   data_i       128-bit state, byte k at [127-8k -: 8] (FIPS-197 order)
//   key_i        128-bit round key, same byte order
//   out_valid_o  result valid        out_ready_i  consumer takes result
//   data_o       128-bit result, same byte order
module aespim_dec_unit (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [1:0]   mode_i,
  input  logic [127:0] data_i,
  input  logic [127:0] key_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [127:0] data_o
);

  localparam int DATA_W = 128;

  typedef enum logic [1:0] {IDLE, COL, DONE} state_t;

  state_t              state, state_nxt;
  logic [1:0]          col_cnt;
  logic [DATA_W-1:0]   data_p0;
  logic [DATA_W-1:0]   key_p0;
  logic                mix_p0;
  logic [DATA_W-1:0]   res_p1;
  logic                accept;
  logic                is_round;
  logic [7:0]          st_b  [16];
  logic [7:0]          key_b [16];
  logic [1:0]          src_col [4];
  logic [1:0]          row_idx [4];
  logic [7:0]          col_b [4];
  logic [31:0]         col_word;
  logic [31:0]         col_out;

  // GF(2^8) arithmetic modulo x^8 + x^4 + x^3 + x + 1
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (x^(2^7-1) squared); maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] acc;
    acc = x;
    for (int i = 0; i < 6; i++) begin
      acc = gf_mul(gf_mul(acc, acc), x);
    end
    return gf_mul(acc, acc);
  endfunction

  // Inverse S-box: undo the affine map, then invert in the field.
  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    logic [7:0] b;
    b = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
    return gf_inv(b);
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    a0 = w[31:24];
    a1 = w[23:16];
    a2 = w[15:8];
    a3 = w[7:0];
    return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
            gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
            gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
            gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
  endfunction

  // Control FSM
  assign is_round = (mode_i == 2'b01) || (mode_i == 2'b10);
  assign accept   = in_valid_i & in_ready_o;

  always_comb begin
    state_nxt   = state;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    case (state)
      IDLE: begin
        in_ready_o = 1'b1;
        if (in_valid_i) state_nxt = is_round ? COL : DONE;
      end
      COL: begin
        if (col_cnt == 2'd3) state_nxt = DONE;
      end
      DONE: begin
        out_valid_o = 1'b1;
        if (out_ready_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      col_cnt <= 2'd0;
    end else begin
      state <= state_nxt;
      // Counter wraps 3 -> 0 on the COL -> DONE transition.
      if (state == COL) col_cnt <= col_cnt + 2'd1;
    end
  end

  // Stage p0: request latch (data path, no reset needed)
  always_ff @(posedge clk_i) begin
    if (!rst_i && accept) begin
      data_p0 <= data_i;
      key_p0  <= key_i;
      mix_p0  <= (mode_i == 2'b01);
    end
  end

  // Stage p0 -> p1: one output column per COL cycle. Sources come only from
  // the latched request, so partially written results never feed back.
  always_comb begin
    for (int k = 0; k < 16; k++) begin
      st_b[k]  = data_p0[8*(15-k) +: 8];
      key_b[k] = key_p0[8*(15-k) +: 8];
    end
    for (int r = 0; r < 4; r++) begin
      row_idx[r] = 2'(r);
      src_col[r] = col_cnt - row_idx[r];
      col_b[r]   = inv_sbox(st_b[{src_col[r], row_idx[r]}]) ^ key_b[{col_cnt, row_idx[r]}];
    end
    col_word = {col_b[0], col_b[1], col_b[2], col_b[3]};
    col_out  = mix_p0 ? inv_mix_col(col_word) : col_word;
  end

  // Stage p1: result register, doubles as data_o
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      res_p1 <= '0;
    end else if (accept && !is_round) begin
      res_p1 <= data_i ^ key_i;
    end else if (state == COL) begin
      case (col_cnt)
        2'd0:    res_p1[127:96] <= col_out;
        2'd1:    res_p1[95:64]  <= col_out;
        2'd2:    res_p1[63:32]  <= col_out;
        default: res_p1[31:0]   <= col_out;
      endcase
    end
  end

  assign data_o = res_p1;

endmodule

// File: tb/tb_aespim_dec_unit.sv
module tb_aespim_dec_unit;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   mode;
  logic [127:0] data_in;
  logic [127:0] key_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] data_out;

  always #5 clk = ~clk;

  aespim_dec_unit dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .mode_i      (mode),
    .data_i      (data_in),
    .key_i       (key_in),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .data_o      (data_out)
  );

  int total = 0;
  int bad   = 0;
  logic [127:0] exp_q [$];
  logic [7:0]   inv_sb [256];

  typedef struct {
    logic [1:0]   mode;
    logic [127:0] data;
    logic [127:0] key;
    logic [127:0] expect_out;
    int           lat;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Reference GF multiply: carry-less product, then reduce by 0x11b.
  function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'h0;
    for (int i = 0; i < 8; i++)
      if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 14; i >= 8; i--)
      if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] ref_affine(input logic [7:0] y);
    return y ^ {y[6:0], y[7]} ^ {y[5:0], y[7:6]} ^ {y[4:0], y[7:5]} ^ {y[3:0], y[7:4]} ^ 8'h63;
  endfunction

  // Inverse S-box built by inverting a forward S-box found by brute force.
  task automatic build_inv_sbox();
    logic [7:0] xb, yb, cb;
    for (int x = 0; x < 256; x++) begin
      xb = 8'(x);
      yb = 8'h00;
      for (int c = 1; c < 256; c++) begin
        cb = 8'(c);
        if (xb != 8'h00 && ref_mul(xb, cb) == 8'h01) yb = cb;
      end
      inv_sb[ref_affine(yb)] = xb;
    end
  endtask

  function automatic logic [127:0] ref_dec(input logic [1:0] m, input logic [127:0] d,
                                           input logic [127:0] k);
    logic [7:0]   t [16];
    logic [7:0]   o [16];
    logic [127:0] res;
    if (m != 2'b01 && m != 2'b10) return d ^ k;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        t[4*c+r] = inv_sb[d[8*(15 - (4*((c - r + 4) % 4) + r)) +: 8]] ^ k[8*(15 - (4*c + r)) +: 8];
    for (int c = 0; c < 4; c++) begin
      if (m == 2'b01) begin
        o[4*c+0] = ref_mul(t[4*c], 8'h0e) ^ ref_mul(t[4*c+1], 8'h0b) ^ ref_mul(t[4*c+2], 8'h0d) ^ ref_mul(t[4*c+3], 8'h09);
        o[4*c+1] = ref_mul(t[4*c], 8'h09) ^ ref_mul(t[4*c+1], 8'h0e) ^ ref_mul(t[4*c+2], 8'h0b) ^ ref_mul(t[4*c+3], 8'h0d);
        o[4*c+2] = ref_mul(t[4*c], 8'h0d) ^ ref_mul(t[4*c+1], 8'h09) ^ ref_mul(t[4*c+2], 8'h0e) ^ ref_mul(t[4*c+3], 8'h0b);
        o[4*c+3] = ref_mul(t[4*c], 8'h0b) ^ ref_mul(t[4*c+1], 8'h0d) ^ ref_mul(t[4*c+2], 8'h09) ^ ref_mul(t[4*c+3], 8'h0e);
      end else begin
        for (int r = 0; r < 4; r++) o[4*c+r] = t[4*c+r];
      end
    end
    for (int i = 0; i < 16; i++) res[8*(15-i) +: 8] = o[i];
    return res;
  endfunction

  // Called #1 after a rising edge with the DUT idle and out_ready=1.
  task automatic run_req(input string nm, input logic [1:0] m, input logic [127:0] d,
                         input logic [127:0] k, input logic [127:0] exp, input int lat_exp);
    int lat;
    logic [127:0] e;
    mode = m; data_in = d; key_in = k; in_valid = 1'b1;
    chk({nm, "_in_ready"}, 128'(in_ready), 128'd1);
    exp_q.push_back(exp);
    @(posedge clk); #1;
    in_valid = 1'b0;
    mode     = 2'($urandom);
    data_in  = {$urandom, $urandom, $urandom, $urandom};
    key_in   = {$urandom, $urandom, $urandom, $urandom};
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, "_latency"}, 128'(lat), 128'(lat_exp));
    e = exp_q.pop_front();
    chk({nm, "_data"}, data_out, e);
    @(posedge clk); #1;
    chk({nm, "_after_ack"}, 128'({in_ready, out_valid}), 128'(2'b10));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0]   m;
    logic [127:0] d, k, e;
    int           lat;
    int           seen;

    tbl[0] = '{2'b00, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h13111d7fe3944a17f307a78b4d2b30c5,
               128'h7ad5fda789ef4e272bca100b3d9ff59f, 1};
    tbl[1] = '{2'b11, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h13111d7fe3944a17f307a78b4d2b30c5,
               128'h7ad5fda789ef4e272bca100b3d9ff59f, 1};
    tbl[2] = '{2'b10, 128'h7ad5fda789ef4e272bca100b3d9ff59f, 128'h0,
               128'hbd6e7c3df2b5779e0b61216e8b10b689, 5};
    tbl[3] = '{2'b10, {16{8'h63}}, {16{8'hff}}, {16{8'hff}}, 5};
    tbl[4] = '{2'b01, {16{8'h7c}}, 128'h0, {16{8'h01}}, 5};
    tbl[5] = '{2'b01, {4{32'h19e33265}}, 128'h0, {4{32'hdb135345}}, 5};

    build_inv_sbox();

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; mode = 2'b00;
    data_in = '0; key_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready", 128'(in_ready), 128'd1);
    chk("reset_out_valid", 128'(out_valid), 128'd0);
    chk("reset_data", data_out, 128'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++)
      run_req($sformatf("vec%0d", i), tbl[i].mode, tbl[i].data, tbl[i].key, tbl[i].expect_out, tbl[i].lat);

    for (int i = 0; i < 10; i++) begin
      m = 2'($urandom_range(0, 3));
      d = {$urandom, $urandom, $urandom, $urandom};
      k = {$urandom, $urandom, $urandom, $urandom};
      run_req($sformatf("rnd%0d_m%0d", i, m), m, d, k, ref_dec(m, d, k),
              (m == 2'b01 || m == 2'b10) ? 5 : 1);
    end

    // Backpressure: result held for 10 cycles, new requests ignored.
    out_ready = 1'b0;
    mode = 2'b10; data_in = tbl[2].data; key_in = 128'h0; in_valid = 1'b1;
    exp_q.push_back(tbl[2].expect_out);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("bp_latency", 128'(lat), 128'd5);
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      mode     = 2'b00;
      data_in  = {$urandom, $urandom, $urandom, $urandom};
      chk($sformatf("bp_hold%0d", i), {data_out[125:0], out_valid, in_ready},
          {exp_q[0][125:0], 1'b1, 1'b0});
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    e = exp_q.pop_front();
    chk("bp_data", data_out, e);
    @(posedge clk); #1;
    chk("bp_release", 128'({in_ready, out_valid}), 128'(2'b10));
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid) seen++;
      @(posedge clk); #1;
    end
    chk("bp_no_queue", 128'(seen), 128'd0);

    // Reset during COL column 2.
    mode = 2'b01; data_in = tbl[4].data; key_in = 128'h0; in_valid = 1'b1;
    exp_q.push_back(tbl[4].expect_out);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    void'(exp_q.pop_front());
    chk("midcol_rst_ctrl", 128'({in_ready, out_valid}), 128'(2'b10));
    chk("midcol_rst_data", data_out, 128'h0);
    run_req("post_rst_decf", 2'b10, tbl[3].data, tbl[3].key, tbl[3].expect_out, 5);

    // Reset while holding a result in DONE.
    out_ready = 1'b0;
    mode = 2'b00; data_in = tbl[0].data; key_in = tbl[0].key; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("done_before_rst", 128'(out_valid), 128'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    chk("done_rst_ctrl", 128'({in_ready, out_valid}), 128'(2'b10));
    chk("done_rst_data", data_out, 128'h0);

    // Request presented while reset is asserted is not accepted.
    rst = 1'b1; mode = 2'b00; data_in = {16{8'ha5}}; key_in = '0; in_valid = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    chk("rst_prio_data", data_out, 128'h0);
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (out_valid) seen++;
      @(posedge clk); #1;
    end
    chk("rst_prio_no_accept", 128'(seen), 128'd0);

    run_req("final_deci", tbl[0].mode, tbl[0].data, tbl[0].key, tbl[0].expect_out, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
